// File: rtl/modexp_controller_if.sv
// Bundles the host start/result handshake and the square/multiply unit handshakes
// of the modular exponentiation controller.
interface modexp_controller_if #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
);
    logic                 ready_in;
    logic [WIDTH-1:0]     base_in;
    logic [EXP_WIDTH-1:0] exponent_in;
    logic [WIDTH-1:0]     modulus_in;
    logic [WIDTH-1:0]     result_out;
    logic                 busy_out;
    logic                 valid_out;
    logic                 error_out;

    logic                 sq_ready_out;
    logic [WIDTH-1:0]     sq_value_out;
    logic [WIDTH-1:0]     sq_result_in;
    logic                 sq_valid_in;

    logic                 mul_ready_out;
    logic [WIDTH-1:0]     mul_a_out;
    logic [WIDTH-1:0]     mul_b_out;
    logic [WIDTH-1:0]     mul_result_in;
    logic                 mul_valid_in;

    logic [WIDTH-1:0]     mod_out;

    // The controller side.
    modport slave (
        input  ready_in, base_in, exponent_in, modulus_in,
        input  sq_result_in, sq_valid_in, mul_result_in, mul_valid_in,
        output result_out, busy_out, valid_out, error_out,
        output sq_ready_out, sq_value_out, mul_ready_out, mul_a_out, mul_b_out, mod_out
    );

    // The environment side: host plus the two arithmetic units.
    modport master (
        output ready_in, base_in, exponent_in, modulus_in,
        output sq_result_in, sq_valid_in, mul_result_in, mul_valid_in,
        input  result_out, busy_out, valid_out, error_out,
        input  sq_ready_out, sq_value_out, mul_ready_out, mul_a_out, mul_b_out, mod_out
    );
endinterface

// File: rtl/modexp_controller.sv
// Right-to-left square-and-multiply sequencer: per exponent bit it launches the
// square and the multiply together on external units and waits for both results.
module modexp_controller #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    modexp_controller_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     acc_cap_q, acc_cap_d;
    logic [WIDTH-1:0]     b_cap_q, b_cap_d;
    logic [WIDTH-1:0]     mod_q, mod_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic                 sq_pend_q, sq_pend_d;
    logic                 mul_pend_q, mul_pend_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 error_q, error_d;

    logic                 finish_now;
    logic                 sq_hit;
    logic                 mul_hit;
    logic                 sq_issue;
    logic                 mul_issue;

    assign finish_now = err_q || (e_q == '0);
    assign sq_hit     = (state_q == S_WAIT) && bus.sq_valid_in  && sq_pend_q;
    assign mul_hit    = (state_q == S_WAIT) && bus.mul_valid_in && mul_pend_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            b_q        <= '0;
            acc_cap_q  <= '0;
            b_cap_q    <= '0;
            mod_q      <= '0;
            result_q   <= '0;
            e_q        <= '0;
            sq_pend_q  <= 1'b0;
            mul_pend_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            acc_cap_q  <= acc_cap_d;
            b_cap_q    <= b_cap_d;
            mod_q      <= mod_d;
            result_q   <= result_d;
            e_q        <= e_d;
            sq_pend_q  <= sq_pend_d;
            mul_pend_q <= mul_pend_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.ready_in) state_d = S_ISSUE;
            S_ISSUE: state_d = finish_now ? S_DONE : S_WAIT;
            S_WAIT:  if (!sq_pend_d && !mul_pend_d) state_d = S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Unit results land in the capture registers so the live operands stay put
    // until both units have answered.
    always_comb begin
        acc_d      = acc_q;
        b_d        = b_q;
        acc_cap_d  = acc_cap_q;
        b_cap_d    = b_cap_q;
        mod_d      = mod_q;
        result_d   = result_q;
        e_d        = e_q;
        sq_pend_d  = sq_pend_q;
        mul_pend_d = mul_pend_q;
        err_d      = err_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        error_d    = error_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ready_in) begin
                    b_d    = bus.base_in;
                    e_d    = bus.exponent_in;
                    mod_d  = bus.modulus_in;
                    acc_d  = (bus.modulus_in == WIDTH'(1)) ? '0 : WIDTH'(1);
                    err_d  = (bus.modulus_in == '0);
                    busy_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!finish_now) begin
                    mul_pend_d = e_q[0];
                    sq_pend_d  = |e_q[EXP_WIDTH-1:1];
                    acc_cap_d  = acc_q;
                    b_cap_d    = b_q;
                end
            end
            S_WAIT: begin
                if (sq_hit) begin
                    b_cap_d   = bus.sq_result_in;
                    sq_pend_d = 1'b0;
                end
                if (mul_hit) begin
                    acc_cap_d  = bus.mul_result_in;
                    mul_pend_d = 1'b0;
                end
                if (!sq_pend_d && !mul_pend_d) begin
                    acc_d = acc_cap_d;
                    b_d   = b_cap_d;
                    e_d   = e_q >> 1;
                end
            end
            S_DONE: begin
                result_d = err_q ? '0 : acc_q;
                error_d  = err_q;
                busy_d   = 1'b0;
                valid_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // The last square is never needed, so only issue it while higher bits remain.
    always_comb begin
        sq_issue  = 1'b0;
        mul_issue = 1'b0;
        if (state_q == S_ISSUE && !finish_now) begin
            sq_issue  = |e_q[EXP_WIDTH-1:1];
            mul_issue = e_q[0];
        end
    end

    assign bus.result_out    = result_q;
    assign bus.busy_out      = busy_q;
    assign bus.valid_out     = valid_q;
    assign bus.error_out     = error_q;
    assign bus.sq_ready_out  = sq_issue;
    assign bus.sq_value_out  = b_q;
    assign bus.mul_ready_out = mul_issue;
    assign bus.mul_a_out     = acc_q;
    assign bus.mul_b_out     = b_q;
    assign bus.mod_out       = mod_q;

endmodule
